// File: rtl/fb_density_counter_if.sv
// Result handshake bundle for fb_density_counter: window result, valid and ready.
interface fb_density_counter_if #(
    parameter int CW = 12
);
    logic [CW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/fb_density_counter.sv
// Windowed ones-density decimator for the feedback bit stream with a one-entry result register.
// Optional macro FB_DENSITY_SIGNED_EN selects bipolar two's-complement output instead of a raw count.
module fb_density_counter #(
    parameter int WIN_LOG2   = 10,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  clk_ext,
    input  logic                  rst_ext,
    input  logic                  en,
    input  logic                  fb_bit,
    fb_density_counter_if.master  smp,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CW = WIN_LOG2 + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [WIN_LOG2-1:0] POS_LAST    = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] POS_ONE     = {{(WIN_LOG2-1){1'b0}}, 1'b1};
    localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic                NO_SETTLE   = (SETTLE_CYC == 32'sd0);
    localparam logic                SKIP_SETTLE = (SETTLE_CYC <= 32'sd1);
`ifdef FB_DENSITY_SIGNED_EN
    localparam logic [CW-1:0]       HALF_SCALE  = {2'b01, {WIN_LOG2{1'b0}}};
`endif

    state_t              state_r;
    logic [3:0]          settle_cnt_r;
    logic [WIN_LOG2-1:0] pos_r;
    logic [WIN_LOG2:0]   ones_r;
    logic                win_done_r;
    logic [CW-1:0]       win_data_r;

    logic                sampling_s;
    logic                done_s;
    logic                xfer_s;
    logic                load_s;
    logic [WIN_LOG2:0]   ones_sum_s;
    logic [CW-1:0]       result_s;

    function automatic logic [CW-1:0] to_sample(input logic [WIN_LOG2:0] cnt);
`ifdef FB_DENSITY_SIGNED_EN
        to_sample = {cnt, 1'b0} - HALF_SCALE;
`else
        to_sample = {1'b0, cnt};
`endif
    endfunction

    // Sampling qualifier, window completion and handshake decisions.
    always_comb begin
        sampling_s = 1'b0;
        case (state_r)
            RUN:     sampling_s = en;
            // With no settle time the enabling edge is already the first window sample.
            IDLE:    sampling_s = en & NO_SETTLE;
            default: sampling_s = 1'b0;
        endcase
        ones_sum_s = ones_r + {{WIN_LOG2{1'b0}}, fb_bit};
        done_s     = sampling_s & (pos_r == POS_LAST);
        result_s   = to_sample(ones_sum_s);
        xfer_s     = smp.sample_valid & smp.sample_ready;
        load_s     = win_done_r & (~smp.sample_valid | smp.sample_ready);
    end

    // FSM, window accumulation, completed-window stage and output register.
    always_ff @(posedge clk_ext) begin
        if (rst_ext) begin
            state_r          <= IDLE;
            settle_cnt_r     <= 4'd0;
            pos_r            <= {WIN_LOG2{1'b0}};
            ones_r           <= {(WIN_LOG2+1){1'b0}};
            win_done_r       <= 1'b0;
            win_data_r       <= {CW{1'b0}};
            smp.sample_data  <= {CW{1'b0}};
            smp.sample_valid <= 1'b0;
            overrun          <= 1'b0;
            busy             <= 1'b0;
        end else begin
            // A finished window is staged one edge before it reaches the output register.
            win_done_r <= done_s;
            if (done_s) begin
                win_data_r <= result_s;
            end

            if (load_s) begin
                smp.sample_data  <= win_data_r;
                smp.sample_valid <= 1'b1;
            end else if (xfer_s) begin
                smp.sample_valid <= 1'b0;
            end

            if (win_done_r & smp.sample_valid & ~smp.sample_ready) begin
                overrun <= 1'b1;
            end

            if (!en) begin
                state_r      <= IDLE;
                settle_cnt_r <= 4'd0;
                pos_r        <= {WIN_LOG2{1'b0}};
                ones_r       <= {(WIN_LOG2+1){1'b0}};
                busy         <= 1'b0;
            end else begin
                if (sampling_s) begin
                    pos_r  <= pos_r + POS_ONE;
                    ones_r <= done_s ? {(WIN_LOG2+1){1'b0}} : ones_sum_s;
                end
                case (state_r)
                    IDLE: begin
                        settle_cnt_r <= 4'd1;
                        busy         <= 1'b1;
                        state_r      <= SKIP_SETTLE ? RUN : SETTLE;
                    end
                    SETTLE: begin
                        busy <= 1'b1;
                        if (settle_cnt_r == SETTLE_LAST) begin
                            state_r <= RUN;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + 4'd1;
                        end
                    end
                    RUN: begin
                        busy <= 1'b1;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fb_density_counter.sv
// Self-checking bench for fb_density_counter (WIN_LOG2=4, SETTLE_CYC=2): vector table plus corner sequences.
`timescale 1ns/1ps
module tb_fb_density_counter;
    localparam int WIN_LOG2   = 4;
    localparam int SETTLE_CYC = 2;
    localparam int CW         = WIN_LOG2 + 2;
    localparam int WIN        = 1 << WIN_LOG2;

    logic clk_ext = 1'b0;
    logic rst_ext;
    logic en;
    logic fb_bit;
    logic overrun;
    logic busy;

    fb_density_counter_if #(.CW(CW)) smp_if ();

    fb_density_counter #(.WIN_LOG2(WIN_LOG2), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk_ext (clk_ext),
        .rst_ext (rst_ext),
        .en      (en),
        .fb_bit  (fb_bit),
        .smp     (smp_if),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk_ext = ~clk_ext;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CW-1:0] exp_q[$];

    typedef struct {
        logic [15:0] bits;
        int          ones;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [CW-1:0] exp_val(input int ones);
        int v;
`ifdef FB_DENSITY_SIGNED_EN
        v = 2 * ones - WIN;
`else
        v = ones;
`endif
        return v[CW-1:0];
    endfunction

    function automatic bit is_last(input int j);
        return (j >= SETTLE_CYC) && (((j - SETTLE_CYC) % WIN) == WIN - 1);
    endfunction

    // Inputs for one rising edge; returns 1 ns after that edge.
    task automatic step(input logic r, input logic e, input logic f, input logic rdy);
        rst_ext             = r;
        en                  = e;
        fb_bit              = f;
        smp_if.sample_ready = rdy;
        @(posedge clk_ext);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
    endtask

    // Scoreboard: a transfer happens at the coming edge; also check held data stays put.
    logic          held_r    = 1'b0;
    logic [CW-1:0] held_data = '0;
    always @(negedge clk_ext) begin
        if (held_r && smp_if.sample_valid)
            check("hold_stable", 32'(smp_if.sample_data), 32'(held_data));
        if (!rst_ext && smp_if.sample_valid && smp_if.sample_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h with no result pending at %0t", smp_if.sample_data, $time);
            end else begin
                check("result", 32'(smp_if.sample_data), 32'(exp_q.pop_front()));
            end
        end
        held_r    <= !rst_ext && smp_if.sample_valid && !smp_if.sample_ready;
        held_data <= smp_if.sample_data;
    end

    initial begin
        vecs[0] = '{16'h0000, 0};
        vecs[1] = '{16'hAAAA, 8};
        vecs[2] = '{16'hFFFF, 16};
        vecs[3] = '{16'h0001, 1};
        vecs[4] = '{16'h00FF, 8};
        vecs[5] = '{16'h7FFF, 15};
        vecs[6] = '{16'h8000, 1};

        // Reset state
        do_reset();
        check("rst_valid", 32'(smp_if.sample_valid), 32'd0);
        check("rst_data", 32'(smp_if.sample_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // All-ones stream with ready high: pulses 18, 34, 50 edges after enable
        for (int j = 0; j <= 52; j++) begin
            if (is_last(j)) exp_q.push_back(exp_val(WIN));
            step(1'b0, 1'b1, 1'b1, 1'b1);
            check("s1_valid", 32'(smp_if.sample_valid), 32'(j == 18 || j == 34 || j == 50));
            if (j == 0) check("s1_busy", 32'(busy), 32'd1);
        end
        check("s1_overrun", 32'(overrun), 32'd0);

        // Vector table: contiguous windows, settle cycles driven with 1s that must be ignored
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < WIN; i++) begin
                if (i == WIN - 1) exp_q.push_back(exp_val(vecs[r].ones));
                step(1'b0, 1'b1, vecs[r].bits[i], 1'b1);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("tbl_drained", 32'(exp_q.size()), 32'd0);
        check("tbl_overrun", 32'(overrun), 32'd0);

        // Ready low 40 cycles after first valid: windows 2 and 3 dropped, overrun sticky
        do_reset();
        for (int j = 0; j <= 68; j++) begin
            if (is_last(j) && j != 33 && j != 49) exp_q.push_back(exp_val(WIN));
            step(1'b0, 1'b1, 1'b1, j >= 59);
            if (j == 33) check("s3_ovr_before", 32'(overrun), 32'd0);
            if (j == 34) check("s3_ovr_set", 32'(overrun), 32'd1);
            if (j == 34) check("s3_held_data", 32'(smp_if.sample_data), 32'(exp_val(WIN)));
            if (j == 59) check("s3_valid_clr", 32'(smp_if.sample_valid), 32'd0);
            if (j == 65) check("s3_valid_gap", 32'(smp_if.sample_valid), 32'd0);
            if (j == 66) check("s3_valid_next", 32'(smp_if.sample_valid), 32'd1);
        end
        check("s3_ovr_sticky", 32'(overrun), 32'd1);
        check("s3_drained", 32'(exp_q.size()), 32'd0);

        // Ready on the exact edge a new window loads: swap without a bubble
        do_reset();
        for (int j = 0; j <= 37; j++) begin
            if (is_last(j)) exp_q.push_back(exp_val(j <= 17 ? WIN : 0));
            step(1'b0, 1'b1, j <= 17, j == 34 || j == 36);
            if (j == 34) begin
                check("s4_valid_kept", 32'(smp_if.sample_valid), 32'd1);
                check("s4_new_data", 32'(smp_if.sample_data), 32'(exp_val(0)));
                check("s4_overrun", 32'(overrun), 32'd0);
            end
            if (j == 36) check("s4_valid_clr", 32'(smp_if.sample_valid), 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("s4_drained", 32'(exp_q.size()), 32'd0);

        // en dropped 5 cycles into a window with one result pending, then re-enabled
        do_reset();
        for (int j = 0; j <= 22; j++) begin
            if (is_last(j)) exp_q.push_back(exp_val(WIN));
            step(1'b0, 1'b1, 1'b1, 1'b0);
        end
        check("s5_pending", 32'(smp_if.sample_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("s5_busy_low", 32'(busy), 32'd0);
        check("s5_still_valid", 32'(smp_if.sample_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("s5_xfer", 32'(smp_if.sample_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            check("s5_no_partial", 32'(smp_if.sample_valid), 32'd0);
        end
        for (int j = 0; j <= 19; j++) begin
            if (is_last(j)) exp_q.push_back(exp_val(WIN));
            step(1'b0, 1'b1, 1'b1, 1'b1);
            if (j == 0) check("s5_rebusy", 32'(busy), 32'd1);
            if (j == 17) check("s5_re_early", 32'(smp_if.sample_valid), 32'd0);
            if (j == 18) check("s5_re_valid", 32'(smp_if.sample_valid), 32'd1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("s5_drained", 32'(exp_q.size()), 32'd0);

        // Reset on the edge a window completes while overrun is set
        do_reset();
        for (int j = 0; j <= 49; j++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
        end
        check("s6_ovr_pre", 32'(overrun), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("s6_valid", 32'(smp_if.sample_valid), 32'd0);
        check("s6_data", 32'(smp_if.sample_data), 32'd0);
        check("s6_overrun", 32'(overrun), 32'd0);
        check("s6_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check("s6_no_result", 32'(smp_if.sample_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_density_counter.md
# fb_density_counter

Feedback-path decimator that sits directly downstream of the gray-code feedback bit selector. It samples the selector's latched 1-bit feedback stream on every rising `clk_ext`. It counts the ones over fixed windows of 2^WIN_LOG2 cycles and hands each window's count to the readout logic through a valid/ready handshake. Overruns are flagged when the consumer stalls.

## Interface
- `WIN_LOG2`, 10, log2 of window length in `clk_ext` cycles; legal range 2..16.
- `SETTLE_CYC`, 2, cycles discarded after enable before the first window starts, giving the upstream latch time to settle; legal range 0..15.
- `clk_ext`  input  1  core clock; all logic on the rising edge.
- `rst_ext`  input  1  reset, synchronous, active-high.
- `en`  input  1  run enable.
- `fb_bit`  input  1  feedback bit from the selector's `out_muxed`.
- `sample_data`  output  WIN_LOG2+2  window result (CW = WIN_LOG2+2).
- `sample_valid`  output  1  `sample_data` holds an unconsumed result.
- `sample_ready`  input  1  consumer accepts the result.
- `overrun`  output  1  sticky: a completed window was dropped.
- `busy`  output  1  FSM is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE → SETTLE when `en`=1; if SETTLE_CYC=0, IDLE → RUN directly.
  - SETTLE counts SETTLE_CYC cycles with `fb_bit` ignored, then → RUN.
  - RUN accumulates the window.
  - Any state → IDLE when `en`=0 (checked before all other transitions).
- RUN uses a WIN_LOG2-bit position counter `pos` and a (WIN_LOG2+1)-bit ones counter `ones`.
  - Each RUN cycle: `ones += fb_bit`, `pos += 1`.
  - On the cycle `pos` = 2^WIN_LOG2−1, the cycle's `fb_bit` is included, the result is produced, and `pos` wraps to 0 and `ones` to 0.
  - The next window starts immediately, with no gap cycles.
- Result arithmetic:
  - `ones` ranges 0..2^WIN_LOG2 and never wraps.
  - Unsigned mode: `sample_data` = `ones`, zero-extended to CW.
- Output register, one entry:
  - A completed window loads the register and sets `sample_valid`, provided the register is empty or is being transferred that same cycle.
  - Transfer occurs when `sample_valid`=1 and `sample_ready`=1. On transfer, `sample_valid` clears unless a new result loads in the same cycle, in which case it stays 1 with the new data.
  - Window completes while `sample_valid`=1 and `sample_ready`=0: the new result is dropped, the held data is unchanged, and `overrun` is set.
  - `sample_data` is stable while `sample_valid`=1 and not transferred.
- `overrun` clears only on `rst_ext`.
- `en` deasserted mid-window: the partial window is discarded and `pos`/`ones` clear. A pending output sample and `overrun` are retained, and the handshake still completes.
- `busy` = 1 in SETTLE and RUN.

## Timing
- Reset values: `sample_data`=0, `sample_valid`=0, `overrun`=0, `busy`=0; FSM=IDLE, `pos`=0, `ones`=0.
- `rst_ext` mid-operation takes priority over everything on the next edge, including a completing window or transfer.
- `en` rising at edge k: SETTLE begins at edge k.
  - The first RUN sample is taken at edge k+SETTLE_CYC.
  - The first window covers edges k+SETTLE_CYC .. k+SETTLE_CYC+2^WIN_LOG2−1.
- Latency: `sample_valid` rises one edge after the last sample of a window, i.e. at edge k+SETTLE_CYC+2^WIN_LOG2.
- Throughput: one result per 2^WIN_LOG2 cycles. Ready tied high never produces an overrun.
- `fb_bit` is used as-is; it is already registered on `clk_ext` upstream, so no extra synchronizer.

## Configuration
- `FB_DENSITY_SIGNED_EN`
  - Defined: `sample_data` is two's-complement bipolar density, 2·`ones` − 2^WIN_LOG2, ranging −2^WIN_LOG2..+2^WIN_LOG2 in CW bits. All-zeros gives −2^WIN_LOG2, a 50 % stream gives 0, and all-ones gives +2^WIN_LOG2. Latency is unchanged; the conversion is done combinationally before the output register.
  - Undefined: unsigned ones count as in Operation; the MSB of `sample_data` is always 0.

## Test plan
- WIN_LOG2=4, SETTLE_CYC=2, `fb_bit`=1, ready=1, `en` raised at edge 10 → `sample_valid` pulses at edges 28, 44, 60 with `sample_data`=16; `overrun`=0.
- Alternating 1/0 stream, unsigned build → every result = 8. Same stimulus with `FB_DENSITY_SIGNED_EN` → 0; all-zeros stream with the macro → −16 (6'b110000).
- Ready held low for 40 cycles after the first valid, `fb_bit`=1 → the first result (16) is held stable and `overrun` sets at the second window's completion. Ready then high → one transfer of 16, and the next result arrives on schedule.
- Ready asserted on the exact edge a new window completes → old result transferred, new result loaded, `sample_valid` stays 1, `overrun`=0.
- `en` dropped 5 cycles into a window with one result pending → FSM goes to IDLE and `busy`=0. The pending result still transfers, and no partial result appears. Re-enable → full SETTLE then a full window.
- `rst_ext` pulsed on the cycle a window completes with `overrun`=1 → next edge all outputs 0, FSM IDLE, no result emitted.
